conv5x5_scheduler: RTL and testbench

//  Sequences one 5x5 convolution layer over an IMG_H x IMG_W 8-bit image for the MNIST accelerator.

---
 rtl/conv5x5_scheduler.sv | 260 ++++++++++++++++++++++++++
 tb/tb_conv5x5_scheduler.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv5x5_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : conv5x5_scheduler
// Description : Sequencer for one KxK convolution layer over an IMG_H x IMG_W
//               8-bit image. Loads a K*K-tap kernel from a valid/ready stream,
//               walks every valid output position row-major, gathers each
//               window from a 1-cycle-latency image RAM, presents window and
//               kernel to an external combinational dot-product unit, and
//               emits the registered result on a valid/ready stream.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, rst_n              clock (rising edge), asynchronous active-low reset
//   start, reload           begin a layer (IDLE only); reload selects a new
//                           kernel load or reuse of the stored kernel
//   busy, done              busy outside IDLE; done pulses after last accept
//   w_valid/w_ready/w_data  kernel weight stream, tap 0 first, row-major
//   img_rd/img_addr         image RAM read strobe and address
//   img_data                read data, one cycle after img_rd
//   win_pixels/win_weights  window and kernel, tap t at [t*IntSize +: IntSize]
//   dp_result               sum of products from the dot-product unit
//   out_valid/out_ready     result stream handshake
//   out_data/out_row/out_col registered result and its output position
// ============================================================================
module conv5x5_scheduler #(
   parameter int IMG_W   = 28,
   parameter int IMG_H   = 28,
   parameter int K       = 5,
   parameter int IntSize = 8,
   parameter int ACC_W   = 21,
   parameter int ADDR_W  = 10
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       start,
   input  logic                       reload,
   output logic                       busy,
   output logic                       done,
   input  logic                       w_valid,
   output logic                       w_ready,
   input  logic [IntSize-1:0]         w_data,
   output logic                       img_rd,
   output logic [ADDR_W-1:0]          img_addr,
   input  logic [IntSize-1:0]         img_data,
   output logic [K*K*IntSize-1:0]     win_pixels,
   output logic [K*K*IntSize-1:0]     win_weights,
   input  logic [ACC_W-1:0]           dp_result,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [ACC_W-1:0]           out_data,
   output logic [$clog2(IMG_H)-1:0]   out_row,
   output logic [$clog2(IMG_W)-1:0]   out_col
);

   localparam int TAPS  = K * K;
   localparam int CNT_W = $clog2(TAPS);
   localparam int KI_W  = $clog2(K);
   localparam int ROW_W = $clog2(IMG_H);
   localparam int COL_W = $clog2(IMG_W);

   localparam logic [CNT_W-1:0] c_last_tap = CNT_W'(TAPS - 1);
   localparam logic [KI_W-1:0]  c_last_k   = KI_W'(K - 1);
   localparam logic [ROW_W-1:0] c_last_row = ROW_W'(IMG_H - K);
   localparam logic [COL_W-1:0] c_last_col = COL_W'(IMG_W - K);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_LOAD_W  = 3'd1,
      S_FETCH   = 3'd2,
      S_WAIT    = 3'd3,
      S_CAPTURE = 3'd4,
      S_EMIT    = 3'd5,
      S_DONE    = 3'd6
   } state_t;

   state_t              r_state;
   state_t              w_next;

   // Tap counter shared by kernel load and window fetch; the (i,j) pair
   // tracks the same tap as row/column inside the window so the address
   // needs no division.
   logic [CNT_W-1:0]    r_cnt;
   logic [KI_W-1:0]     r_ti;
   logic [KI_W-1:0]     r_tj;
   logic [ROW_W-1:0]    r_row;
   logic [COL_W-1:0]    r_col;

   // Read pipeline: remembers which window slot the in-flight read targets.
   logic                r_rd_valid;
   logic [CNT_W-1:0]    r_rd_tap;

   logic                w_last_pos;
   logic [ADDR_W-1:0]   w_addr_row;

   assign w_last_pos = (r_row == c_last_row) && (r_col == c_last_col);

   // ------------------------------------------------------------------------
   // FSM state register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // ------------------------------------------------------------------------
   // FSM next state and decoded outputs
   // ------------------------------------------------------------------------
   always_comb begin
      w_next    = r_state;
      busy      = (r_state != S_IDLE);
      done      = 1'b0;
      w_ready   = 1'b0;
      img_rd    = 1'b0;
      out_valid = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_next = reload ? S_LOAD_W : S_FETCH;
            end
         end
         S_LOAD_W: begin
            w_ready = 1'b1;
            if (w_valid && (r_cnt == c_last_tap)) begin
               w_next = S_FETCH;
            end
         end
         S_FETCH: begin
            img_rd = 1'b1;
            if (r_cnt == c_last_tap) begin
               w_next = S_WAIT;
            end
         end
         S_WAIT: begin
            // Last read of the window lands in its slot this cycle.
            w_next = S_CAPTURE;
         end
         S_CAPTURE: begin
            w_next = S_EMIT;
         end
         S_EMIT: begin
            out_valid = 1'b1;
            if (out_ready) begin
               w_next = w_last_pos ? S_DONE : S_FETCH;
            end
         end
         S_DONE: begin
            done   = 1'b1;
            w_next = S_IDLE;
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Counters, position and output registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt      <= '0;
         r_ti       <= '0;
         r_tj       <= '0;
         r_row      <= '0;
         r_col      <= '0;
         r_rd_valid <= 1'b0;
         r_rd_tap   <= '0;
         out_data   <= '0;
         out_row    <= '0;
         out_col    <= '0;
      end else begin
         r_rd_valid <= img_rd;
         r_rd_tap   <= r_cnt;
         case (r_state)
            S_LOAD_W: begin
               if (w_valid) begin
                  r_cnt <= (r_cnt == c_last_tap) ? '0 : r_cnt + 1'b1;
               end
            end
            S_FETCH: begin
               if (r_cnt == c_last_tap) begin
                  r_cnt <= '0;
                  r_ti  <= '0;
                  r_tj  <= '0;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
                  if (r_tj == c_last_k) begin
                     r_tj <= '0;
                     r_ti <= r_ti + 1'b1;
                  end else begin
                     r_tj <= r_tj + 1'b1;
                  end
               end
            end
            S_CAPTURE: begin
               out_data <= dp_result;
               out_row  <= r_row;
               out_col  <= r_col;
            end
            S_EMIT: begin
               // The last position is left in place; DONE clears it.
               if (out_ready && !w_last_pos) begin
                  if (r_col == c_last_col) begin
                     r_col <= '0;
                     r_row <= r_row + 1'b1;
                  end else begin
                     r_col <= r_col + 1'b1;
                  end
               end
            end
            S_DONE: begin
               r_row <= '0;
               r_col <= '0;
            end
            default: begin
            end
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // Image address: (row+i)*IMG_W + (col+j)
   // ------------------------------------------------------------------------
   assign w_addr_row = ADDR_W'(r_row) + ADDR_W'(r_ti);
   assign img_addr   = w_addr_row * ADDR_W'(IMG_W) + ADDR_W'(r_col) + ADDR_W'(r_tj);

   // ------------------------------------------------------------------------
   // Kernel and window storage, one register pair per tap
   // ------------------------------------------------------------------------
   for (genvar t = 0; t < TAPS; t++) begin : g_tap
      logic [IntSize-1:0] r_wt;
      logic [IntSize-1:0] r_pix;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_wt <= '0;
         end else if ((r_state == S_LOAD_W) && w_valid && (r_cnt == CNT_W'(t))) begin
            r_wt <= w_data;
         end
      end

      // Only reads issued in FETCH set r_rd_valid, so the window moves only
      // in FETCH and the WAIT cycle that follows it.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_pix <= '0;
         end else if (r_rd_valid && (r_rd_tap == CNT_W'(t))) begin
            r_pix <= img_data;
         end
      end

      assign win_weights[t*IntSize +: IntSize] = r_wt;
      assign win_pixels[t*IntSize +: IntSize]  = r_pix;
   end

endmodule
`default_nettype wire

// File: tb/tb_conv5x5_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_conv5x5_scheduler
// Description : Directed bench for conv5x5_scheduler with an image RAM model
//               and a behavioural dot-product unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_conv5x5_scheduler;

   logic          clk;
   logic          rst_n;
   logic          start;
   logic          reload;
   logic          busy;
   logic          done;
   logic          w_valid;
   logic          w_ready;
   logic [7:0]    w_data;
   logic          img_rd;
   logic [9:0]    img_addr;
   logic [7:0]    img_data;
   logic [199:0]  win_pixels;
   logic [199:0]  win_weights;
   logic [20:0]   dp_result;
   logic          out_valid;
   logic          out_ready;
   logic [20:0]   out_data;
   logic [4:0]    out_row;
   logic [4:0]    out_col;

   conv5x5_scheduler dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .reload      (reload),
      .busy        (busy),
      .done        (done),
      .w_valid     (w_valid),
      .w_ready     (w_ready),
      .w_data      (w_data),
      .img_rd      (img_rd),
      .img_addr    (img_addr),
      .img_data    (img_data),
      .win_pixels  (win_pixels),
      .win_weights (win_weights),
      .dp_result   (dp_result),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .out_row     (out_row),
      .out_col     (out_col)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Image RAM with one cycle read latency
   logic [7:0] mem [0:1023];
   always @(posedge clk) begin
      if (img_rd) img_data <= mem[img_addr];
   end

   // Combinational dot-product unit
   always_comb begin
      dp_result = '0;
      for (int t = 0; t < 25; t++) begin
         dp_result = dp_result + 21'(win_pixels[t*8 +: 8]) * 21'(win_weights[t*8 +: 8]);
      end
   end

   int n_total = 0;
   int n_bad   = 0;

   task automatic chk(input string name, input longint act, input longint exp);
      n_total++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic longint exp_val(input int kind, input int r, input int c);
      case (kind)
         0:       return 25;
         1:       return ((r + 2) * 28 + c + 2) % 256;
         default: return 1625625;
      endcase
   endfunction

   // ------------------------------------------------------------------------
   // Monitor: address sequence, output sequence, done pulse
   // ------------------------------------------------------------------------
   bit          mon_en = 0;
   bit          forbid_wready = 0;
   bit          expect_done = 0;
   int          run_id = 0;
   int          run_kind = 0;
   int          a_r, a_c, a_t;
   int          o_r, o_c;
   int          n_out;
   int          done_cnt;
   logic [20:0] res [4][576];

   always @(negedge clk) begin
      if (mon_en) begin
         if (img_rd) begin
            chk("img_addr", img_addr, (a_r + a_t / 5) * 28 + a_c + a_t % 5);
            a_t++;
            if (a_t == 25) begin
               a_t = 0;
               if (a_c == 23) begin a_c = 0; a_r++; end
               else a_c++;
            end
         end
         if (forbid_wready) chk("w_ready_low", w_ready, 0);
         if (expect_done) begin
            chk("done_pulse", done, 1);
            if (done) done_cnt++;
            expect_done = 0;
         end else begin
            chk("done_low", done, 0);
         end
         if (out_valid && out_ready) begin
            chk("out_row", out_row, o_r);
            chk("out_col", out_col, o_c);
            chk("out_data", out_data, exp_val(run_kind, o_r, o_c));
            if (n_out < 576) res[run_id][o_r * 24 + o_c] = out_data;
            n_out++;
            if (o_r == 23 && o_c == 23) expect_done = 1;
            if (o_c == 23) begin o_c = 0; o_r++; end
            else o_c++;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Stimulus helpers
   // ------------------------------------------------------------------------
   logic [7:0] kern [25];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_layer(input bit rl);
      start  = 1'b1;
      reload = rl;
      tick();
      start  = 1'b0;
      reload = 1'b0;
   endtask

   task automatic load_kernel(input bit gaps);
      int  tap   = 0;
      int  guard = 0;
      bit  take;
      while (tap < 25 && guard < 500) begin
         w_valid = !(gaps && (guard % 3 == 1));
         w_data  = w_valid ? kern[tap] : 8'h5A;
         @(negedge clk);
         take = w_valid && w_ready;
         tick();
         if (take) tap++;
         guard++;
      end
      w_valid = 1'b0;
      w_data  = 8'h00;
      chk("load_taps", tap, 25);
   endtask

   task automatic run_layer(input int rid, input int kind, input bit rl,
                            input bit gaps, input bit stall, input bit pulse);
      bit seen;
      run_id = rid;  run_kind = kind;
      a_r = 0; a_c = 0; a_t = 0; o_r = 0; o_c = 0;
      n_out = 0; done_cnt = 0; expect_done = 0;
      forbid_wready = !rl;
      out_ready = !stall;
      mon_en = 1;
      start_layer(rl);
      if (rl) load_kernel(gaps);
      if (stall) begin
         seen = 0;
         for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (out_valid) begin seen = 1; break; end
         end
         chk("first_emit_seen", seen, 1);
         for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("stall_valid", out_valid, 1);
            chk("stall_data", out_data, 25);
            chk("stall_row", out_row, 0);
            chk("stall_col", out_col, 0);
            chk("stall_img_rd", img_rd, 0);
         end
         tick();
         out_ready = 1'b1;
      end
      if (pulse) begin
         repeat (50) tick();
         start = 1'b1; reload = 1'b1;
         repeat (3) tick();
         start = 1'b0; reload = 1'b0;
      end
      for (int k = 0; k < 20000; k++) begin
         if (done_cnt > 0) break;
         @(posedge clk);
      end
      @(negedge clk);
      chk("run_done_count", done_cnt, 1);
      chk("run_outputs", n_out, 576);
      @(negedge clk);
      chk("idle_after_done", busy, 0);
      mon_en = 0;
      forbid_wready = 0;
      tick();
   endtask

   typedef struct {
      int     run;
      int     row;
      int     col;
      longint exp;
   } spot_t;

   spot_t spots [13];

   initial begin
      // Spot results: {run, row, col, expected out_data}
      spots[0]  = '{0,  0,  0, 25};
      spots[1]  = '{0, 12,  7, 25};
      spots[2]  = '{0, 23, 23, 25};
      spots[3]  = '{1,  0,  0, 58};
      spots[4]  = '{1,  0,  1, 59};
      spots[5]  = '{1,  1,  0, 86};
      spots[6]  = '{1,  9,  5, 59};
      spots[7]  = '{1,  8, 10, 36};
      spots[8]  = '{1, 23, 23, 213};
      spots[9]  = '{2,  0,  0, 58};
      spots[10] = '{2, 23, 23, 213};
      spots[11] = '{3,  0,  0, 1625625};
      spots[12] = '{3, 23, 23, 1625625};

      rst_n = 1'b0; start = 1'b0; reload = 1'b0;
      w_valid = 1'b0; w_data = 8'h00; out_ready = 1'b1;
      for (int a = 0; a < 1024; a++) mem[a] = 8'h00;

      repeat (3) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_w_ready", w_ready, 0);
      chk("rst_img_rd", img_rd, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_row", out_row, 0);
      chk("rst_out_col", out_col, 0);
      chk("rst_win_pixels", win_pixels == '0, 1);
      chk("rst_win_weights", win_weights == '0, 1);
      tick();
      rst_n = 1'b1;
      tick();

      // Run 0: all ones, weight stream gaps, output stall at first EMIT
      for (int a = 0; a < 784; a++) mem[a] = 8'd1;
      for (int t = 0; t < 25; t++) kern[t] = 8'd1;
      run_layer(0, 0, 1'b1, 1'b1, 1'b1, 1'b0);

      // Run 1: ramp image, centre-tap kernel
      for (int a = 0; a < 784; a++) mem[a] = 8'(a % 256);
      for (int t = 0; t < 25; t++) kern[t] = (t == 12) ? 8'd1 : 8'd0;
      run_layer(1, 1, 1'b1, 1'b0, 1'b0, 1'b0);

      // Run 2: reuse stored kernel, start pulses while busy are ignored
      run_layer(2, 1, 1'b0, 1'b0, 1'b0, 1'b1);

      // Reset in the middle of FETCH
      for (int a = 0; a < 784; a++) mem[a] = 8'd255;
      for (int t = 0; t < 25; t++) kern[t] = 8'd255;
      start_layer(1'b1);
      load_kernel(1'b0);
      repeat (10) tick();
      #2;
      chk("pre_reset_img_rd", img_rd, 1);
      rst_n = 1'b0;
      #1;
      chk("async_rst_busy", busy, 0);
      chk("async_rst_img_rd", img_rd, 0);
      chk("async_rst_out_valid", out_valid, 0);
      chk("async_rst_kernel", win_weights == '0, 1);
      repeat (2) tick();
      rst_n = 1'b1;
      tick();

      // Run 3: full-scale values after reset, fresh kernel
      run_layer(3, 2, 1'b1, 1'b0, 1'b0, 1'b0);

      for (int i = 0; i < 13; i++) begin
         chk($sformatf("spot_r%0d_%0d_%0d", spots[i].run, spots[i].row, spots[i].col),
             res[spots[i].run][spots[i].row * 24 + spots[i].col], spots[i].exp);
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
